// File: rtl/conv_job_scheduler.sv
// Round-robin scheduler sharing one convolution engine between NREQ requesters.
// It clears and starts the engine, tags each output pixel for the result buffer and acks the job.

module conv_job_ack_lane #(
  parameter int ID  = 0,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           fire,
  input  logic [IDW-1:0] sel,
  output logic           ack
);
  always_ff @(posedge clk) begin
    if (rst) ack <= 1'b0;
    else     ack <= fire && (sel == IDW'(ID));
  end
endmodule

module conv_job_scheduler #(
  parameter int NREQ      = 4,
  parameter int ACC_WIDTH = 32,
  parameter int HEIGHT    = 4,
  parameter int WIDTH     = 4,
  parameter int K         = 2,
  parameter int TIMEOUT   = 1024
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NREQ-1:0]                             req,
  output logic [NREQ-1:0]                             ack,
  output logic                                        err,
  output logic                                        timed_out,
  output logic                                        busy,
  output logic                                        eng_rst,
  output logic                                        eng_start,
  output logic [$clog2(NREQ)-1:0]                     eng_sel,
  input  logic                                        eng_done,
  input  logic                                        eng_out_valid,
  input  logic [ACC_WIDTH-1:0]                        eng_out_pixel,
  output logic                                        wr_en,
  output logic [$clog2(NREQ)-1:0]                     wr_id,
  output logic [$clog2((HEIGHT-K+1)*(WIDTH-K+1)+1)-1:0] wr_addr,
  output logic [ACC_WIDTH-1:0]                        wr_data
);
  localparam int NPIX = (HEIGHT-K+1)*(WIDTH-K+1);
  localparam int IDW  = $clog2(NREQ);
  localparam int PW   = $clog2(NPIX+1);
  localparam int TW   = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, RUN, FINISH} state_t;

  typedef struct packed {
    logic                 en;
    logic [IDW-1:0]       id;
    logic [PW-1:0]        addr;
    logic [ACC_WIDTH-1:0] data;
  } wr_t;

  state_t         state, state_n;
  logic [IDW-1:0] last_grant, last_grant_n, sel_q, sel_n, winner, cand;
  logic [PW-1:0]  pix_cnt, pix_cnt_n;
  logic [TW-1:0]  tmo_cnt, tmo_cnt_n;
  logic           over, over_n, found, fire;
  logic           busy_q, busy_n, erst_q, erst_n, estart_q, estart_n;
  logic           err_q, err_n, tmo_q, tmo_n;
  wr_t            wr_q, wr_n;

  // Scan starts just past the last grant so a held request yields to others.
  always_comb begin
    winner = last_grant;
    found  = 1'b0;
    cand   = last_grant;
    for (int i = 0; i < NREQ; i++) begin
      cand = (cand == IDW'(NREQ-1)) ? '0 : cand + IDW'(1);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    sel_n        = sel_q;
    pix_cnt_n    = pix_cnt;
    over_n       = over;
    tmo_cnt_n    = tmo_cnt;
    busy_n       = busy_q;
    erst_n       = 1'b0;
    estart_n     = 1'b0;
    err_n        = 1'b0;
    tmo_n        = 1'b0;
    fire         = 1'b0;
    wr_n         = wr_q;
    wr_n.en      = 1'b0;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (found) begin
          sel_n        = winner;
          last_grant_n = winner;
          busy_n       = 1'b1;
          pix_cnt_n    = '0;
          over_n       = 1'b0;
          tmo_cnt_n    = '0;
          erst_n       = 1'b1;
          state_n      = CLEAR;
        end
      end
      CLEAR: begin
        estart_n = 1'b1;
        state_n  = LAUNCH;
      end
      LAUNCH: state_n = RUN;
      RUN: begin
        tmo_cnt_n = tmo_cnt + TW'(1);
        if (eng_out_valid) begin
          wr_n = '{en: 1'b1, id: sel_q, addr: pix_cnt, data: eng_out_pixel};
          // Address saturates at NPIX; surplus pixels are remembered as overflow.
          if (pix_cnt == PW'(NPIX)) over_n = 1'b1;
          else                      pix_cnt_n = pix_cnt + PW'(1);
        end
        if (eng_done || tmo_cnt == TW'(TIMEOUT-1)) begin
          fire    = 1'b1;
          tmo_n   = !eng_done;
          err_n   = !eng_done || over_n || (pix_cnt_n != PW'(NPIX));
          state_n = FINISH;
        end
      end
      FINISH: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IDW'(NREQ-1);
      sel_q      <= '0;
      pix_cnt    <= '0;
      over       <= 1'b0;
      tmo_cnt    <= '0;
      busy_q     <= 1'b0;
      erst_q     <= 1'b0;
      estart_q   <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= 1'b0;
      wr_q       <= '0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      sel_q      <= sel_n;
      pix_cnt    <= pix_cnt_n;
      over       <= over_n;
      tmo_cnt    <= tmo_cnt_n;
      busy_q     <= busy_n;
      erst_q     <= erst_n;
      estart_q   <= estart_n;
      err_q      <= err_n;
      tmo_q      <= tmo_n;
      wr_q       <= wr_n;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_ack
    conv_job_ack_lane #(.ID(g), .IDW(IDW)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .fire (fire),
      .sel  (sel_q),
      .ack  (ack[g])
    );
  end

  assign err       = err_q;
  assign timed_out = tmo_q;
  assign busy      = busy_q;
  assign eng_rst   = erst_q;
  assign eng_start = estart_q;
  assign eng_sel   = sel_q;
  assign wr_en     = wr_q.en;
  assign wr_id     = wr_q.id;
  assign wr_addr   = wr_q.addr;
  assign wr_data   = wr_q.data;
endmodule

// File: tb/tb_conv_job_scheduler.sv
// Directed + randomized bench for conv_job_scheduler with a behavioural engine and job model.
module tb_conv_job_scheduler;
  localparam int NREQ = 4, ACC = 32, H = 4, W = 4, KS = 2, TMO = 16;
  localparam int NPIX = (H-KS+1)*(W-KS+1);

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] ack;
  logic            err, timed_out, busy, eng_rst, eng_start;
  logic [1:0]      eng_sel, wr_id;
  logic            eng_done, eng_out_valid, wr_en;
  logic [ACC-1:0]  eng_out_pixel, wr_data;
  logic [3:0]      wr_addr;

  int vectors = 0, miscompares = 0, model_last = NREQ-1;

  conv_job_scheduler #(.NREQ(NREQ), .ACC_WIDTH(ACC), .HEIGHT(H), .WIDTH(W), .K(KS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .err(err), .timed_out(timed_out), .busy(busy),
    .eng_rst(eng_rst), .eng_start(eng_start), .eng_sel(eng_sel), .eng_done(eng_done),
    .eng_out_valid(eng_out_valid), .eng_out_pixel(eng_out_pixel), .wr_en(wr_en), .wr_id(wr_id),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin reference: first pending requester after the previous winner.
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    for (int i = 1; i <= NREQ; i++)
      if (((r >> ((last + i) % NREQ)) & 4'd1) != 0) return (last + i) % NREQ;
    return -1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, ack, 0);      chk({tag, "_err"}, err, 0);
    chk({tag, "_tmo"}, timed_out, 0); chk({tag, "_busy"}, busy, 0);
    chk({tag, "_erst"}, eng_rst, 0); chk({tag, "_estart"}, eng_start, 0);
    chk({tag, "_sel"}, eng_sel, 0);  chk({tag, "_wren"}, wr_en, 0);
    chk({tag, "_wrid"}, wr_id, 0);   chk({tag, "_wraddr"}, wr_addr, 0);
    chk({tag, "_wrdata"}, wr_data, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; eng_out_valid = 1'b0; eng_done = 1'b0;
    step();
    chk_all_zero("reset");
    rst = 1'b0;
    model_last = NREQ-1;
  endtask

  // One job from grant to the idle cycle after ack. exp_id<0 means use the model.
  task automatic do_job(input int npix, input bit done_en, input int gap, input bit seq_data,
                        input int abort_at, input int exp_id, input bit drop_req);
    int id, k;
    bit v, d, ended, tmo;
    logic [ACC-1:0] px;
    id = (exp_id >= 0) ? exp_id : rr_pick(req, model_last);
    eng_out_valid = 1'($urandom_range(0, 1));
    step();
    chk("grant_busy", busy, 1); chk("grant_erst", eng_rst, 1);
    chk("grant_sel", eng_sel, id); chk("grant_wren", wr_en, 0);
    model_last = id;
    if (drop_req) req = '0;
    step();
    chk("clear_estart", eng_start, 1); chk("clear_erst", eng_rst, 0); chk("clear_wren", wr_en, 0);
    eng_done = 1'b0;
    step();
    chk("launch_estart", eng_start, 0); chk("launch_wren", wr_en, 0);
    k = 0; ended = 1'b0;
    for (int c = 0; c < TMO && !ended; c++) begin
      if (abort_at >= 0 && k == abort_at) begin
        do_reset();
        return;
      end
      v = 1'b0; d = 1'b0;
      if (k < npix) v = (gap == 0) || ($urandom_range(0, gap) == 0);
      if (done_en && k == npix) d = 1'b1;
      else if (done_en && v && k + 1 == npix && $urandom_range(0, 1) == 1) d = 1'b1;
      px = seq_data ? ACC'(10 + k) : ACC'($urandom);
      eng_out_valid = v; eng_done = d; eng_out_pixel = px;
      tmo = !d && (c == TMO-1);
      ended = d || tmo;
      step();
      chk("wr_en", wr_en, v);
      if (v) begin
        chk("wr_id", wr_id, id);
        chk("wr_addr", wr_addr, (k < NPIX) ? k : NPIX);
        chk("wr_data", wr_data, px);
        k++;
      end
      if (ended) begin
        chk("fin_ack", ack, 64'(1) << id);
        chk("fin_err", err, (tmo || k != NPIX) ? 1 : 0);
        chk("fin_tmo", timed_out, tmo);
        chk("fin_busy", busy, 1);
      end else begin
        chk("run_ack", ack, 0);
      end
    end
    eng_out_valid = 1'($urandom_range(0, 1));
    step();
    chk("idle_busy", busy, 0); chk("idle_ack", ack, 0); chk("idle_err", err, 0);
    chk("idle_tmo", timed_out, 0); chk("idle_wren", wr_en, 0);
  endtask

  initial begin
    rst = 1'b1; req = '0; eng_done = 1'b0; eng_out_valid = 1'b0; eng_out_pixel = '0;
    step();
    do_reset();
    step();
    chk("idle_noreq_busy", busy, 0);
    chk("idle_noreq_erst", eng_rst, 0);

    // Single job, 9 sequential pixels 10..18 to requester 0.
    req = 4'b0001;
    do_job(NPIX, 1'b1, 0, 1'b1, -1, 0, 1'b0);
    req = '0;

    // Contention from reset: 0,1,2,3,0.
    do_reset();
    req = 4'b1111;
    do_job(NPIX, 1'b1, 0, 1'b0, -1, 0, 1'b0);
    do_job(NPIX, 1'b1, 0, 1'b0, -1, 1, 1'b0);
    do_job(NPIX, 1'b1, 0, 1'b0, -1, 2, 1'b0);
    do_job(NPIX, 1'b1, 0, 1'b0, -1, 3, 1'b0);
    do_job(NPIX, 1'b1, 0, 1'b0, -1, 0, 1'b0);

    // Fairness from reset with two requesters: 1,3,1.
    do_reset();
    req = 4'b1010;
    do_job(NPIX, 1'b1, 0, 1'b0, -1, 1, 1'b0);
    do_job(NPIX, 1'b1, 0, 1'b0, -1, 3, 1'b0);
    do_job(NPIX, 1'b1, 0, 1'b0, -1, 1, 1'b0);

    // Short job, timeout job, overlong job.
    req = 4'b0001;
    do_job(5, 1'b1, 0, 1'b0, -1, -1, 1'b0);
    do_job(3, 1'b0, 0, 1'b0, -1, -1, 1'b0);
    do_job(NPIX + 2, 1'b1, 0, 1'b0, -1, -1, 1'b0);

    // Reset after 3 pixels, then requester 2 wins first.
    do_job(NPIX, 1'b1, 0, 1'b0, 3, -1, 1'b0);
    req = 4'b0100;
    chk("post_abort_ack", ack, 0);
    do_job(NPIX, 1'b1, 0, 1'b0, -1, 2, 1'b0);

    // Randomized jobs: mixed request sets, counts, gaps and dropped requests.
    for (int j = 0; j < 14; j++) begin
      int sel, np;
      req = 4'($urandom_range(1, 15));
      sel = $urandom_range(0, 3);
      np  = (sel == 0) ? NPIX - 2 : (sel == 1) ? NPIX + 1 : NPIX;
      do_job(np, ($urandom_range(0, 5) != 0), $urandom_range(0, 1), 1'b0, -1, -1,
             1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/conv_job_scheduler.md
Name: conv_job_scheduler

Overview:
- Shares one convolution engine (sliding-window MAC, start/done, out_pixel/out_valid stream) between NREQ requesters.
- Arbitrates round-robin, clears and launches the engine, and tags each output pixel with requester id and raster address for the result buffer.
- Returns a per-requester ack with error status.
- Sits between the layer sequencer's request ports and the conv engine / output SRAM write port.

Parameters:
- NREQ, 4: number of requesters (≥2).
- ACC_WIDTH, 32: engine output pixel width.
- HEIGHT, 4: input matrix height.
- WIDTH, 4: input matrix width.
- K, 2: kernel size; expected pixels NPIX = (HEIGHT-K+1)*(WIDTH-K+1).
- TIMEOUT, 1024: max cycles in RUN before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req  in  NREQ  per-requester job request; held high until matching ack.
- ack  out  NREQ  one-cycle completion pulse to the granted requester.
- err  out  1  valid with ack; 1 = pixel-count mismatch or timeout.
- timed_out  out  1  valid with ack; 1 = job aborted by timeout.
- busy  out  1  high from grant until the ack cycle inclusive.
- eng_rst  out  1  one-cycle engine clear (engine only leaves FINISHED via reset).
- eng_start  out  1  one-cycle engine start.
- eng_sel  out  $clog2(NREQ)  granted id; selects the requester's matrix/kernel into the engine.
- eng_done  in  1  engine done level.
- eng_out_valid  in  1  engine pixel strobe.
- eng_out_pixel  in  ACC_WIDTH  engine pixel.
- wr_en  out  1  result write strobe.
- wr_id  out  $clog2(NREQ)  requester owning the write.
- wr_addr  out  $clog2(NPIX+1)  raster pixel index.
- wr_data  out  ACC_WIDTH  pixel value.

Behaviour:
- All outputs registered.
- Reset values:
  - ack=0, err=0, timed_out=0, busy=0.
  - eng_rst=0, eng_start=0, eng_sel=0.
  - wr_en=0, wr_id=0, wr_addr=0, wr_data=0.
  - state=IDLE, pix_cnt=0, tmo_cnt=0, last_grant=NREQ-1.
- Reset mid-job abandons the job silently (no ack).
- State machine:
  - IDLE, any req high:
    - Winner = first set bit scanning from (last_grant+1) mod NREQ upward with wrap.
    - Latch eng_sel=winner, last_grant=winner, busy=1, pix_cnt=0, tmo_cnt=0.
    - eng_rst=1 next cycle; go to CLEAR.
  - IDLE, no req: hold; busy=0.
  - CLEAR: eng_rst=0, eng_start=1; go to LAUNCH.
  - LAUNCH: eng_start=0; go to RUN.
  - RUN:
    - Each cycle eng_out_valid=1: next cycle wr_en=1, wr_id=eng_sel, wr_addr=pix_cnt, wr_data=eng_out_pixel; pix_cnt++. Otherwise wr_en=0.
    - tmo_cnt++ every cycle.
    - eng_done=1: go to FINISH. A pixel strobed in the same cycle is still written.
    - tmo_cnt reaches TIMEOUT-1 without done: set timed_out; go to FINISH.
  - FINISH, one cycle:
    - ack[eng_sel]=1.
    - err=1 if timed_out or pix_cnt≠NPIX, counting a write issued this cycle.
    - busy stays 1 this cycle; next state IDLE, with busy, ack, err and timed_out cleared there.
- Job timing: grant to first eng_start is 2 cycles; min 1 idle cycle between consecutive jobs. No back-to-back grant from FINISH.
- req semantics:
  - req dropped mid-job: job still completes and acks.
  - req held after ack: treated as a new request, but round-robin gives other pending requesters priority.
- Pixels beyond NPIX are still written; wr_addr saturates at NPIX and err is set.
- eng_out_valid/eng_done outside RUN are ignored.
- eng_rst is also issued before every job, so stale engine done from a prior job never leaks.

Test Plan:
- Single job: HEIGHT=WIDTH=4, K=2, req=0001, engine emits 9 pixels 10..18 → eng_rst at cycle 1, eng_start at cycle 2; wr_addr 0..8 carrying data 10..18 with wr_id=0; ack=0001 with err=0.
- Contention: req=1111 held, each job emits 9 pixels → grant order 0,1,2,3,0; each ack one-hot; busy low exactly 1 cycle between jobs.
- Fairness after reset: req=1010 → requester 1 first, then 3, then 1.
- Short job: engine raises done after 5 pixels → ack with err=1, timed_out=0; wr_addr 0..4 only.
- Timeout: TIMEOUT=16, engine never raises done → ack after 16 RUN cycles with err=1, timed_out=1.
- Reset mid-RUN after 3 pixels → all outputs 0 next cycle, no ack; a new req=0100 is granted to requester 2 first.
